// File: rtl/fibo_pkg.sv
// Shared types and ASCII helpers for the Fibonacci LCD scroller.
package fibo_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [127:0] WELCOME_A = "Press START to  ";
    localparam logic [127:0] WELCOME_B = "show Fibonacci..";

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_A10 = 8'h37;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_F   = 8'h46;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (ASCII_0 + {4'b0, nib}) : (ASCII_A10 + {4'b0, nib});
    endfunction

    // Index 0..99 to two ASCII digits, tens digit in the upper byte.
    function automatic logic [15:0] dec2(input logic [6:0] val);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = val / 7'd10;
        ones = val - tens * 7'd10;
        return {ASCII_0 + {1'b0, tens}, ASCII_0 + {1'b0, ones}};
    endfunction

endpackage

// File: rtl/fibo_table_fill.sv
// Sequential Fibonacci table writer (one entry per cycle) with two read ports.
// FIBO_SATURATE_EN: clamp the overflowing entry and all later ones to all-ones.
module fibo_table_fill
    import fibo_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 25,
    localparam int IW    = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IW-1:0]    i_addr_a,
    input  logic [IW-1:0]    i_addr_b,
    output logic [WIDTH-1:0] o_data_a,
    output logic [WIDTH-1:0] o_data_b,
    output logic             o_ready,
    output logic             o_last,
    output logic             o_overflow
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [WIDTH-1:0] r_table [DEPTH];
    logic [IW-1:0]    r_wr_idx;
    logic [WIDTH-1:0] r_p1;
    logic [WIDTH-1:0] r_p2;
    logic             r_ready;
    logic             r_overflow;
    logic [WIDTH:0]   w_sum;
    logic             w_seed;
    logic             w_carry;
    logic [WIDTH-1:0] w_val;

    always_comb begin
        w_sum   = {1'b0, r_p1} + {1'b0, r_p2};
        w_seed  = (32'(r_wr_idx) < 32'd2);
        w_carry = !w_seed && w_sum[WIDTH];
        if (r_wr_idx == '0)
            w_val = '0;
        else if (w_seed)
            w_val = WIDTH'(1);
        else
            w_val = w_sum[WIDTH-1:0];
`ifdef FIBO_SATURATE_EN
        if (w_carry || r_overflow)
            w_val = '1;
`endif
    end

    assign o_last     = !r_ready && (r_wr_idx == LAST_IDX);
    assign o_ready    = r_ready;
    assign o_overflow = r_overflow;
    assign o_data_a   = r_table[i_addr_a];
    assign o_data_b   = r_table[i_addr_b];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_table[i] <= '0;
            r_wr_idx   <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!r_ready) begin
            r_table[r_wr_idx] <= w_val;
            r_p2              <= r_p1;
            r_p1              <= w_val;
            if (w_carry)
                r_overflow <= 1'b1;
            if (o_last)
                r_ready <= 1'b1;
            else
                r_wr_idx <= r_wr_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fibo_lcd_scroller.sv
// Fibonacci table scroller driving two 16-char LCD rows.
// Optional FIBO_SATURATE_EN selects saturating table entries (see fibo_table_fill).
//   state | meaning
//   FILL  | table being written, welcome text shown, start pulse latched
//   WAIT  | table ready, welcome text shown until start
//   RUN   | rows show entries show_a/show_b, stepping every PERIOD cycles
module fibo_lcd_scroller
    import fibo_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 25,
    parameter int PERIOD  = 70000000,
    parameter int ROW_GAP = 1
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_pulse,
    input  logic         dir_pulse,
    input  logic         pause_pulse,
    output logic [127:0] row_a,
    output logic [127:0] row_b,
    output logic         ready,
    output logic         running,
    output logic         reverse,
    output logic         overflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(PERIOD);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] GAP_IDX  = IW'(ROW_GAP);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_start_latched;
    logic [IW-1:0]    r_show_a;
    logic [IW-1:0]    r_show_b;
    logic [CW-1:0]    r_cnt;
    logic             r_pause;
    logic             r_reverse;
    logic [127:0]     r_row_a;
    logic [127:0]     r_row_b;
    logic             w_last;
    logic             w_load_rows;
    logic [WIDTH-1:0] w_data_a;
    logic [WIDTH-1:0] w_data_b;

    fibo_table_fill #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fill (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_addr_a   (r_show_a),
        .i_addr_b   (r_show_b),
        .o_data_a   (w_data_a),
        .o_data_b   (w_data_b),
        .o_ready    (ready),
        .o_last     (w_last),
        .o_overflow (overflow)
    );

    function automatic logic [IW-1:0] step_idx(input logic [IW-1:0] idx, input logic rev);
        if (rev)
            return (idx == '0) ? LAST_IDX : idx - 1'b1;
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // "Fnn " then WIDTH/4 hex digits MSB-first, space padded to 16 chars.
    function automatic logic [127:0] fmt_row(input logic [IW-1:0] idx, input logic [WIDTH-1:0] val);
        logic [127:0] line;
        line           = {16{ASCII_SP}};
        line[127:120]  = ASCII_F;
        line[119:104]  = dec2(7'(idx));
        for (int i = 0; i < WIDTH / 4; i++)
            line[95 - 8*i -: 8] = nibble_to_ascii(val[WIDTH - 1 - 4*i -: 4]);
        return line;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_FILL;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FILL: if (w_last) w_next = ST_WAIT;
            ST_WAIT: if (start_pulse || r_start_latched) w_next = ST_RUN;
            ST_RUN:  w_next = ST_RUN;
            default: w_next = ST_FILL;
        endcase
    end

    always_comb begin
        running     = (r_state == ST_RUN);
        w_load_rows = (r_state == ST_RUN) || (r_state == ST_WAIT && w_next == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_latched <= 1'b0;
            r_show_a        <= '0;
            r_show_b        <= GAP_IDX;
            r_cnt           <= '0;
            r_pause         <= 1'b0;
            r_reverse       <= 1'b0;
            r_row_a         <= WELCOME_A;
            r_row_b         <= WELCOME_B;
        end else begin
            if (r_state == ST_FILL && start_pulse)
                r_start_latched <= 1'b1;
            else if (r_state == ST_WAIT)
                r_start_latched <= 1'b0;

            if (w_load_rows) begin
                r_row_a <= fmt_row(r_show_a, w_data_a);
                r_row_b <= fmt_row(r_show_b, w_data_b);
            end

            if (r_state == ST_WAIT && w_next == ST_RUN) begin
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                // A restart wins over a step landing on the same cycle.
                if (start_pulse) begin
                    r_cnt <= '0;
                end else if (!r_pause) begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt    <= '0;
                        r_show_a <= step_idx(r_show_a, r_reverse);
                        r_show_b <= step_idx(r_show_b, r_reverse);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (dir_pulse)
                    r_reverse <= ~r_reverse;
                if (pause_pulse)
                    r_pause <= ~r_pause;
            end
        end
    end

    assign row_a   = r_row_a;
    assign row_b   = r_row_b;
    assign reverse = r_reverse;

endmodule
